// File: rtl/empty_addr_arb.sv
// empty_addr_arb: free block address pool with round-robin allocator.
// Define EPTY_ADDR_DUP_CHK_EN to enable the double-free bitmap check.
module empty_addr_arb #(
  parameter int NUM_PORT = 4,
  parameter int AW       = 12,
  parameter int DEPTH    = 4096
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic [NUM_PORT-1:0] iAddrReq,
  output logic [AW-1:0]       oEptyAddr,
  output logic [NUM_PORT-1:0] oEptyAddrVld,
  input  logic [AW-1:0]       iRlsAddr,
  input  logic                iRlsAddrVld,
  output logic                oRlsAddrRdy,
  output logic [AW:0]         oFreeCnt,
  output logic                oPoolEmpty,
  output logic                oInitDone,
  output logic                oDupErr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [RW-1:0] RR_LAST  = RW'(NUM_PORT - 1);
  localparam logic [RW-1:0] RR_ONE   = RW'(1);
  localparam logic [RW:0]   RR_NUM   = (RW+1)'(NUM_PORT);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t state;
  state_t stateNxt;

  logic [AW-1:0] mem [DEPTH];

  logic [PW-1:0]       rdPtr;
  logic [PW-1:0]       wrPtr;
  logic [RW-1:0]       rrPtr;
  logic [NUM_PORT-1:0] cool1;
  logic [NUM_PORT-1:0] cool2;
  logic [NUM_PORT-1:0] elig;
  logic [NUM_PORT-1:0] grant;
  logic [RW-1:0]       winner;
  logic [RW:0]         idx;
  logic                found;

  logic          initWr;
  logic          runEn;
  logic          pop;
  logic          rlsAcc;
  logic          rlsWr;
  logic          memWr;
  logic [AW-1:0] memWrData;
  logic [AW-1:0] popAddr;
  logic [AW:0]   cntNxt;

  function automatic logic [PW-1:0] ptrInc(
    input logic [PW-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  function automatic logic [RW-1:0] rrInc(
    input logic [RW-1:0] p
  );
    return (p == RR_LAST) ? '0 : p + RR_ONE;
  endfunction

  // State register: INIT after reset, RUN once the pool is filled
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= ST_INIT;
    end else begin
      state <= stateNxt;
    end
  end

  // Next state: leave INIT after the last slot is written
  always_comb begin
    stateNxt = state;
    unique case (state)
      ST_INIT: if (wrPtr == PTR_LAST) stateNxt = ST_RUN;
      ST_RUN:  stateNxt = ST_RUN;
    endcase
  end

  // State decode: fill enable, run enable, release ready
  always_comb begin
    initWr      = 1'b0;
    runEn       = 1'b0;
    oRlsAddrRdy = 1'b0;
    unique case (state)
      ST_INIT: initWr = 1'b1;
      ST_RUN: begin
        runEn       = 1'b1;
        oRlsAddrRdy = (oFreeCnt < CNT_FULL);
      end
    endcase
  end

  assign elig = iAddrReq & ~(cool1 | cool2);

  // Round-robin search: first eligible port at or after rrPtr
  always_comb begin
    grant  = '0;
    winner = rrPtr;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      idx = {1'b0, rrPtr} + (RW+1)'(i);
      if (idx >= RR_NUM) idx = idx - RR_NUM;
      if (!found && elig[idx[RW-1:0]]) begin
        found                = 1'b1;
        winner               = idx[RW-1:0];
        grant[idx[RW-1:0]]   = 1'b1;
      end
    end
  end

  assign popAddr = mem[rdPtr];
  assign pop     = runEn && (oFreeCnt != '0) && found;
  assign rlsAcc  = iRlsAddrVld && oRlsAddrRdy;

`ifdef EPTY_ADDR_DUP_CHK_EN
  logic [DEPTH-1:0] allocMap;
  logic [PW-1:0]    rlsIdx;
  logic [PW-1:0]    popIdx;
  logic             rlsInRange;
  logic             rlsDup;

  assign rlsIdx     = iRlsAddr[PW-1:0];
  assign popIdx     = popAddr[PW-1:0];
  assign rlsInRange = ({1'b0, iRlsAddr} < CNT_FULL);
  assign rlsDup     = !rlsInRange || !allocMap[rlsIdx];
  assign rlsWr      = rlsAcc && !rlsDup;

  // Allocated bitmap: set on grant, cleared on a genuine release
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      allocMap <= '0;
    end else if (initWr) begin
      allocMap <= '0;
    end else begin
      if (pop)   allocMap[popIdx] <= 1'b1;
      if (rlsWr) allocMap[rlsIdx] <= 1'b0;
    end
  end

  // Double-free flag: one-cycle pulse after a rejected release
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oDupErr <= 1'b0;
    end else begin
      oDupErr <= rlsAcc && rlsDup;
    end
  end
`else
  assign rlsWr   = rlsAcc;
  assign oDupErr = 1'b0;
`endif

  assign memWr     = initWr || rlsWr;
  assign memWrData = initWr ? AW'(wrPtr) : iRlsAddr;

  // Free count update: fill, release and pop, net zero when both
  always_comb begin
    cntNxt = oFreeCnt;
    if (initWr) begin
      cntNxt = oFreeCnt + CNT_ONE;
    end else if (rlsWr && !pop) begin
      cntNxt = oFreeCnt + CNT_ONE;
    end else if (pop && !rlsWr) begin
      cntNxt = oFreeCnt - CNT_ONE;
    end
  end

  // Pool storage: fill pattern during INIT, released addresses in RUN
  always_ff @(posedge iClk) begin
    if (memWr) mem[wrPtr] <= memWrData;
  end

  // Tail pointer, count and status flags
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wrPtr      <= '0;
      oFreeCnt   <= '0;
      oPoolEmpty <= 1'b1;
      oInitDone  <= 1'b0;
    end else begin
      if (memWr) wrPtr <= ptrInc(wrPtr);
      oFreeCnt   <= cntNxt;
      oPoolEmpty <= (cntNxt == '0);
      oInitDone  <= (stateNxt == ST_RUN);
    end
  end

  // Head pointer, grant outputs, RR pointer and cooldown history
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rdPtr        <= '0;
      rrPtr        <= '0;
      cool1        <= '0;
      cool2        <= '0;
      oEptyAddr    <= '0;
      oEptyAddrVld <= '0;
    end else begin
      oEptyAddrVld <= pop ? grant : '0;
      cool1        <= pop ? grant : '0;
      cool2        <= cool1;
      if (pop) begin
        oEptyAddr <= popAddr;
        rdPtr     <= ptrInc(rdPtr);
        rrPtr     <= rrInc(winner);
      end
    end
  end

endmodule

// File: doc/empty_addr_arb.md
Name: empty_addr_arb

Overview:
Free-block address pool and allocator for the switch's packet buffer. It holds every unused block address in a circular FIFO and hands them out one per cycle to NUM_PORT unpack requesters under round-robin arbitration. It takes back addresses released by the dequeue side. It sits between the per-port unpack stages (consumers of iEptyAddr/iEptyAddrVld) and the output/read side (producer of recycled addresses).

Parameters:
NUM_PORT, 4, number of unpack requesters
AW, 12, block address width
DEPTH, 4096, number of buffer blocks; 2 <= DEPTH <= 2**AW

Ports:
iClk  in  1  clock
iRst_n  in  1  asynchronous active-low reset
iAddrReq  in  NUM_PORT  per-port request level (driven from each unpack's empty-addr ready)
oEptyAddr  out  AW  granted block address, shared bus
oEptyAddrVld  out  NUM_PORT  one-hot grant strobe, qualifies oEptyAddr
iRlsAddr  in  AW  released block address
iRlsAddrVld  in  1  release valid
oRlsAddrRdy  out  1  release ready
oFreeCnt  out  AW+1  number of free addresses in pool
oPoolEmpty  out  1  oFreeCnt == 0
oInitDone  out  1  pool initialised, grants enabled
oDupErr  out  1  double-free pulse (see Optional Feature)

Behaviour:
- Reset values: oEptyAddr=0, oEptyAddrVld=0, oRlsAddrRdy=0, oFreeCnt=0, oPoolEmpty=1, oInitDone=0, oDupErr=0; RR pointer=0; rd/wr pointers=0.
- FSM INIT -> RUN.
  - INIT: writes addresses 0..DEPTH-1 into FIFO slots 0..DEPTH-1, one per cycle; oFreeCnt increments each cycle; no grants; oRlsAddrRdy=0.
  - After DEPTH cycles: RUN, oInitDone=1, oFreeCnt=DEPTH, wr pointer wraps to 0.
  - Reset mid-operation returns to INIT and restarts from address 0; pool contents are discarded.
- Grant (RUN): in cycle t, eligible = iAddrReq & ~cooldown mask.
  - If eligible != 0 and pool not empty: pick the first eligible port at or after the RR pointer (wrapping), pop the head.
  - Cycle t+1: oEptyAddr=popped address, oEptyAddrVld=one-hot of the winner. Vld is a single-cycle pulse.
  - RR pointer advances to winner+1 (mod NUM_PORT).
  - At most one grant per cycle.
- Cooldown: a port granted in cycle t is excluded from eligibility in cycles t+1 and t+2. This covers the requester's registered ready deassertion and prevents double allocation. A port whose request is still high at t+3 is served again.
- Pool empty: no grant; requests wait; oEptyAddrVld=0; RR pointer unchanged.
- Release: oRlsAddrRdy = (state==RUN) && (oFreeCnt < DEPTH). When iRlsAddrVld && oRlsAddrRdy, iRlsAddr is written at the wr pointer in the same cycle. The address is poppable from the next cycle.
- Release at full (count==DEPTH): rdy low, release stalls; this is a protocol error upstream.
- Simultaneous grant and release in one cycle: both happen; oFreeCnt unchanged.
- Release into an empty pool: no bypass. Grant possible one cycle later.
- Counts: oFreeCnt is registered, +1 per accepted release, -1 per pop, net 0 when both occur. Pointers are log2(DEPTH)-bit and wrap modulo DEPTH; empty/full are derived from oFreeCnt, not from pointer equality.
- oPoolEmpty is registered and consistent with oFreeCnt in the same cycle.

Optional Feature:
EPTY_ADDR_DUP_CHK_EN
- Defined: a DEPTH-bit allocated bitmap is kept.
  - Set on grant, cleared on accepted release; all clear at reset/INIT.
  - A release whose bit is already clear is acknowledged (rdy as normal) but not written; oFreeCnt unchanged; oDupErr pulses high for 1 cycle after acceptance.
  - A release with iRlsAddr >= DEPTH is handled the same way.
- Undefined: no bitmap; every accepted release is written; oDupErr tied 0.

Test Plan:
- Reset, DEPTH=8 -> oInitDone rises exactly 8 cycles after reset release; oFreeCnt=8; first grants return addresses 0,1,2,... in order.
- iAddrReq=4'b1111 held continuously, DEPTH=4096 -> grants cycle ports 0,1,2,3,0,...; each port re-served no sooner than 3 cycles after its previous grant; never two vld bits high; addresses strictly sequential.
- DEPTH=8, port 0 held requesting -> exactly 8 grants, then oPoolEmpty=1, no further vld. Release 0x005 -> next grant to port 0 carries 0x005, 2 cycles after the release.
- Grant and release in the same cycle with oFreeCnt=100 -> oFreeCnt stays 100 the next cycle.
- Assert iRst_n low during RUN with oFreeCnt=3 -> all outputs return to reset values; INIT restarts and the first grant after re-init is address 0.
- With EPTY_ADDR_DUP_CHK_EN: release 0x010 twice after a single grant -> first accepted, second pulses oDupErr for 1 cycle, oFreeCnt incremented only once.
